// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses the combinational instruction ROM,
// and fills the IF/ID register. It handles stall, flush and redirect requests from
// later stages, and it traps fetch addresses that fall outside the ROM window or are
// not word aligned.
module fetch_stage #(
  parameter logic [31:0] RESET_PC      = 32'hBFC00000,
  parameter int          IMEM_A_LENGTH = 12,
  parameter logic [31:0] NOP_INSTR     = 32'h00000013
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     stall_f,
  input  logic                     flush_d,
  input  logic                     pc_src_e,
  input  logic [31:0]              pc_target_e,
  input  logic [31:0]              instr_f,
  output logic [IMEM_A_LENGTH-1:0] imem_addr_f,
  output logic [31:0]              instr_d,
  output logic [31:0]              pc_d,
  output logic [31:0]              pc_plus4_d,
  output logic                     valid_d,
  output logic                     fault,
  output logic [31:0]              fault_pc
);

  localparam logic [31:0] WINDOW = 32'd1 << IMEM_A_LENGTH;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t      state, next_state;

  logic [31:0] pc_f, pc_next;
  logic [31:0] pc_plus4_f;
  logic [31:0] instr_next, pc_d_next, pc_plus4_next;
  logic        valid_next;
  logic        fault_next;
  logic [31:0] fault_pc_next;

  // An address is fetchable only when it is word aligned and inside the ROM window.
  // Subtracting the base first means addresses below the base wrap to huge
  // offsets and fail the same unsigned compare.
  function automatic logic is_legal(input logic [31:0] addr);
    logic [31:0] offset;
    offset = addr - RESET_PC;
    return (addr[1:0] == 2'b00) && (offset < WINDOW);
  endfunction

  // Sequential PC increment wraps at 32 bits; is_legal catches the wrap.
  assign pc_plus4_f  = pc_f + 32'd4;
  assign imem_addr_f = pc_f[IMEM_A_LENGTH-1:0];

  // State register; reset always wins, including out of FAULT.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= BOOT;
    else        state <= next_state;
  end

  // Next-state, next-PC and next IF/ID contents; everything holds unless a rule fires.
  always_comb begin
    next_state    = state;
    pc_next       = pc_f;
    instr_next    = instr_d;
    pc_d_next     = pc_d;
    pc_plus4_next = pc_plus4_d;
    valid_next    = valid_d;
    fault_next    = fault;
    fault_pc_next = fault_pc;

    case (state)
      BOOT: begin
        instr_next    = NOP_INSTR;
        pc_d_next     = 32'd0;
        pc_plus4_next = 32'd0;
        valid_next    = 1'b0;
        next_state    = RUN;
      end

      RUN: begin
        if (pc_src_e) begin
          // Redirect outranks stall and flush; the wrong-path word becomes a bubble.
          instr_next    = NOP_INSTR;
          pc_d_next     = 32'd0;
          pc_plus4_next = 32'd0;
          valid_next    = 1'b0;
          if (is_legal(pc_target_e)) begin
            pc_next = pc_target_e;
          end else begin
            next_state    = FAULT;
            fault_next    = 1'b1;
            fault_pc_next = pc_target_e;
          end
        end else if (flush_d) begin
          instr_next    = NOP_INSTR;
          pc_d_next     = 32'd0;
          pc_plus4_next = 32'd0;
          valid_next    = 1'b0;
          if (!stall_f) pc_next = pc_plus4_f;
        end else if (!stall_f) begin
          // Normal fetch; the current word is delivered even if the next address is bad.
          instr_next    = instr_f;
          pc_d_next     = pc_f;
          pc_plus4_next = pc_plus4_f;
          valid_next    = 1'b1;
          if (is_legal(pc_plus4_f)) begin
            pc_next = pc_plus4_f;
          end else begin
            next_state    = FAULT;
            fault_next    = 1'b1;
            fault_pc_next = pc_plus4_f;
          end
        end
      end

      FAULT: begin
        instr_next    = NOP_INSTR;
        pc_d_next     = 32'd0;
        pc_plus4_next = 32'd0;
        valid_next    = 1'b0;
      end

      default: begin
        next_state    = BOOT;
        instr_next    = NOP_INSTR;
        pc_d_next     = 32'd0;
        pc_plus4_next = 32'd0;
        valid_next    = 1'b0;
      end
    endcase
  end

  // PC, IF/ID register and sticky fault capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_f       <= RESET_PC;
      instr_d    <= NOP_INSTR;
      pc_d       <= 32'd0;
      pc_plus4_d <= 32'd0;
      valid_d    <= 1'b0;
      fault      <= 1'b0;
      fault_pc   <= 32'd0;
    end else begin
      pc_f       <= pc_next;
      instr_d    <= instr_next;
      pc_d       <= pc_d_next;
      pc_plus4_d <= pc_plus4_next;
      valid_d    <= valid_next;
      fault      <= fault_next;
      fault_pc   <= fault_pc_next;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a combinational ROM model where word[i] = i.
`timescale 1ns/1ps
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        stall_f;
  logic        flush_d;
  logic        pc_src_e;
  logic [31:0] pc_target_e;
  logic [31:0] instr_f;
  logic [11:0] imem_addr_f;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pc_plus4_d;
  logic        valid_d;
  logic        fault;
  logic [31:0] fault_pc;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] NOP = 32'h00000013;

  fetch_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall_f     (stall_f),
    .flush_d     (flush_d),
    .pc_src_e    (pc_src_e),
    .pc_target_e (pc_target_e),
    .instr_f     (instr_f),
    .imem_addr_f (imem_addr_f),
    .instr_d     (instr_d),
    .pc_d        (pc_d),
    .pc_plus4_d  (pc_plus4_d),
    .valid_d     (valid_d),
    .fault       (fault),
    .fault_pc    (fault_pc)
  );

  // ROM model: word index i holds value i.
  assign instr_f = {22'd0, imem_addr_f[11:2]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".valid"},    32'(valid_d),     32'd0);
    check({tag, ".instr"},    instr_d,          NOP);
    check({tag, ".pc_d"},     pc_d,             32'd0);
    check({tag, ".pc4_d"},    pc_plus4_d,       32'd0);
    check({tag, ".fault"},    32'(fault),       32'd0);
    check({tag, ".fault_pc"}, fault_pc,         32'd0);
    check({tag, ".addr"},     32'(imem_addr_f), 32'h000);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; stall_f = 1'b0; flush_d = 1'b0; pc_src_e = 1'b0; pc_target_e = 32'd0;
    tick(); tick();
    check_reset_values("rst");

    // 1: reset release, BOOT cycle then first real fetch
    rst_n = 1'b1;
    tick();
    check("boot.valid", 32'(valid_d), 32'd0);
    check("boot.addr",  32'(imem_addr_f), 32'h000);
    tick();
    check("f0.valid", 32'(valid_d), 32'd1);
    check("f0.pc_d",  pc_d, 32'hBFC00000);
    check("f0.pc4",   pc_plus4_d, 32'hBFC00004);
    check("f0.instr", instr_d, 32'd0);
    check("f0.addr",  32'(imem_addr_f), 32'h004);
    tick(); tick(); tick();
    check("f3.addr",  32'(imem_addr_f), 32'h010);
    check("f3.pc_d",  pc_d, 32'hBFC0000C);
    check("f3.instr", instr_d, 32'd3);

    // 2: stall for three cycles at pc_f = 0xBFC00010
    stall_f = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall.addr",  32'(imem_addr_f), 32'h010);
      check("stall.pc_d",  pc_d, 32'hBFC0000C);
      check("stall.instr", instr_d, 32'd3);
      check("stall.valid", 32'(valid_d), 32'd1);
    end
    stall_f = 1'b0;
    tick();
    check("unstall.pc_d",  pc_d, 32'hBFC00010);
    check("unstall.instr", instr_d, 32'd4);
    check("unstall.addr",  32'(imem_addr_f), 32'h014);

    // flush alone advances the PC; flush with stall holds it
    flush_d = 1'b1;
    tick();
    check("flush.valid", 32'(valid_d), 32'd0);
    check("flush.pc_d",  pc_d, 32'd0);
    check("flush.instr", instr_d, NOP);
    check("flush.addr",  32'(imem_addr_f), 32'h018);
    stall_f = 1'b1;
    tick();
    check("flstall.addr",  32'(imem_addr_f), 32'h018);
    check("flstall.valid", 32'(valid_d), 32'd0);

    // 3: redirect wins over simultaneous stall and flush
    pc_src_e = 1'b1; pc_target_e = 32'hBFC00100;
    tick();
    check("redir.addr",  32'(imem_addr_f), 32'h100);
    check("redir.valid", 32'(valid_d), 32'd0);
    check("redir.instr", instr_d, NOP);
    pc_src_e = 1'b0; stall_f = 1'b0; flush_d = 1'b0;
    tick();
    check("redir1.pc_d",  pc_d, 32'hBFC00100);
    check("redir1.instr", instr_d, 32'h40);
    check("redir1.valid", 32'(valid_d), 32'd1);

    // 4: misaligned redirect target traps; inputs then ignored
    pc_src_e = 1'b1; pc_target_e = 32'hBFC00102;
    tick();
    check("mis.fault",    32'(fault), 32'd1);
    check("mis.fault_pc", fault_pc, 32'hBFC00102);
    check("mis.valid",    32'(valid_d), 32'd0);
    check("mis.addr",     32'(imem_addr_f), 32'h104);
    for (int i = 0; i < 10; i++) begin
      pc_src_e = i[0]; pc_target_e = 32'hBFC00020; stall_f = i[1]; flush_d = i[2];
      tick();
      check("ign.fault",    32'(fault), 32'd1);
      check("ign.fault_pc", fault_pc, 32'hBFC00102);
      check("ign.valid",    32'(valid_d), 32'd0);
      check("ign.addr",     32'(imem_addr_f), 32'h104);
    end
    pc_src_e = 1'b0; stall_f = 1'b0; flush_d = 1'b0;

    // 6a: reset while in FAULT
    rst_n = 1'b0;
    tick();
    check_reset_values("rstf");
    rst_n = 1'b1;
    tick();
    check("boot2.valid", 32'(valid_d), 32'd0);
    check("boot2.addr",  32'(imem_addr_f), 32'h000);

    // 5: free-run to the last ROM word
    n = 0;
    while (imem_addr_f != 12'hFFC && n < 2000) begin
      tick();
      n++;
    end
    check("run.timeout", 32'(imem_addr_f), 32'hFFC);
    check("run.fault",   32'(fault), 32'd0);
    tick();
    check("end.instr",    instr_d, 32'h3FF);
    check("end.valid",    32'(valid_d), 32'd1);
    check("end.pc_d",     pc_d, 32'hBFC00FFC);
    check("end.pc4",      pc_plus4_d, 32'hBFC01000);
    check("end.fault",    32'(fault), 32'd1);
    check("end.fault_pc", fault_pc, 32'hBFC01000);
    tick();
    check("end1.valid", 32'(valid_d), 32'd0);
    check("end1.instr", instr_d, NOP);
    check("end1.fault", 32'(fault), 32'd1);

    // 6b: reset again, then reset in the middle of a stall
    rst_n = 1'b0;
    tick();
    check_reset_values("rst2");
    rst_n = 1'b1;
    tick(); tick(); tick();
    check("pre.addr", 32'(imem_addr_f), 32'h008);
    stall_f = 1'b1;
    tick();
    check("pre.stall", 32'(imem_addr_f), 32'h008);
    rst_n = 1'b0;
    tick();
    check_reset_values("rsts");
    rst_n = 1'b1; stall_f = 1'b0;
    tick();
    check("boot3.valid", 32'(valid_d), 32'd0);
    check("boot3.addr",  32'(imem_addr_f), 32'h000);
    tick();
    check("f0b.pc_d",  pc_d, 32'hBFC00000);
    check("f0b.valid", 32'(valid_d), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
